quad_decoder: RTL

Quadrature decoder that turns the two-phase A/B signals from an incremental encoder into the single-cycle enable (E) and direction (D) commands the 8-bit up/down counter consumes. It synchronises and glitch-filters each phase, then decodes legal Gray-code steps into one-cycle count pulses. Illegal two-bit jumps raise a sticky error flag. It sits between the encoder pins and the counter's E/D inputs, in the same clk/rst domain.

---
 rtl/quad_decoder_pkg.sv | 31 +++
 rtl/quad_decoder_if.sv | 20 ++
 rtl/quad_decoder_filter.sv | 47 ++++
 rtl/quad_decoder.sv | 118 +++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - shared types, direction codes and Gray-step decode for the quadrature decoder
package quad_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Forward Gray order {A,B}: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic next_is_up(input logic [1:0] prev, input logic [1:0] cur);
    case (prev)
      2'b00:   return (cur == 2'b01);
      2'b01:   return (cur == 2'b11);
      2'b11:   return (cur == 2'b10);
      default: return (cur == 2'b00);
    endcase
  endfunction

  function automatic logic next_is_down(input logic [1:0] prev, input logic [1:0] cur);
    case (prev)
      2'b00:   return (cur == 2'b10);
      2'b10:   return (cur == 2'b11);
      2'b11:   return (cur == 2'b01);
      default: return (cur == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder pins in, counter E/D commands and status out
interface quad_decoder_if;
  logic       a_in;
  logic       b_in;
  logic       clr_err;
  logic       E;
  logic       D;
  logic       err;
  logic [1:0] phase;

  modport master (
    output a_in, b_in, clr_err,
    input  E, D, err, phase
  );

  modport slave (
    input  a_in, b_in, clr_err,
    output E, D, err, phase
  );
endinterface

// File: rtl/quad_decoder_filter.sv
// rtl/quad_decoder_filter.sv - synchroniser chain plus mismatch-count glitch filter for one encoder phase
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_filt   = r_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // The flip happens on the cycle the count would reach FILTER_LEN, so a
  // level held FILTER_LEN cycles passes and anything shorter is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_filt <= ~r_filt;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - filtered A/B phases decoded into one-cycle E/D count commands with sticky err
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic          clk,
  input  logic          rst,
  quad_decoder_if.slave bus
);

  localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
  localparam int IW       = $clog2(INIT_CYC + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC);

  logic          w_a_filt;
  logic          w_b_filt;
  logic [1:0]    w_phase;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_init_cnt;
  logic [IW-1:0] w_init_cnt_nxt;
  logic [1:0]    r_phase;
  logic [1:0]    r_prev;
  logic [1:0]    w_prev_nxt;
  logic          r_e;
  logic          r_d;
  logic          r_err;
  logic          w_e_nxt;
  logic          w_d_nxt;
  logic          w_err_nxt;

  quad_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (bus.a_in),
    .o_filt (w_a_filt)
  );

  quad_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (bus.b_in),
    .o_filt (w_b_filt)
  );

  assign w_phase = {w_a_filt, w_b_filt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_phase    <= 2'b00;
      r_prev     <= 2'b00;
      r_e        <= 1'b0;
      r_d        <= DIR_UP;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_phase    <= w_phase;
      r_prev     <= w_prev_nxt;
      r_e        <= w_e_nxt;
      r_d        <= w_d_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // INIT exits on the same edge r_phase captures w_phase, so prev and
  // r_phase agree on the first RUN cycle and the start-up level is adopted.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_prev_nxt     = r_prev;
    w_e_nxt        = 1'b0;
    w_d_nxt        = r_d;
    w_err_nxt      = r_err;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_prev_nxt  = w_phase;
          w_state_nxt = ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + IW'(1);
        end
      end
      ST_RUN: begin
        w_prev_nxt = r_phase;
        if (next_is_up(r_prev, r_phase)) begin
          w_e_nxt = 1'b1;
          w_d_nxt = DIR_UP;
        end else if (next_is_down(r_prev, r_phase)) begin
          w_e_nxt = 1'b1;
          w_d_nxt = DIR_DOWN;
        end
        if ((r_prev ^ r_phase) == 2'b11) begin
          w_err_nxt = 1'b1;
        end else if (bus.clr_err) begin
          w_err_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign bus.E     = r_e;
  assign bus.D     = r_d;
  assign bus.err   = r_err;
  assign bus.phase = r_phase;

endmodule
